// File: rtl/cam_stream_source.sv
// Camera timing to valid/ready pixel stream; exactly IMG_WIDTH*IMG_HEIGHT pixels per emitted frame.
// One cycle min latency; camera side never stalls, backpressure absorbed by FIFO then pixels dropped/padded.

module cam_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module cam_stream_source #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int W          = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PAD_VALUE  = 0
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       cam_vsync,
  input  logic                                       cam_href,
  input  logic                                       cam_pix_valid,
  input  logic [W-1:0]                               cam_data,
  output logic                                       y_valid,
  input  logic                                       y_ready,
  output logic [W-1:0]                               y_data,
  output logic                                       y_sof,
  output logic                                       y_eof,
  output logic                                       overflow,
  output logic                                       frame_skipped,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0]  pix_count
);
  localparam int N  = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  typedef enum logic [1:0] {WAIT_SOF, CAPTURE, DROP, PAD} state_t;

  state_t        state, state_nxt;
  logic          vsync_q, vsync_primed;
  logic          fall, rise, qual;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          wr_en, rd_en, room;
  logic          f_full, f_empty;
  logic [W-1:0]  wr_pix;
  logic [W+1:0]  wr_dat, rd_dat;
  logic          ovf_set, skip_set;

  // vsync_primed masks the first cycle after reset so a vsync already low is not taken as a frame start
  assign fall = vsync_primed && vsync_q && !cam_vsync;
  assign rise = !vsync_q && cam_vsync;
  assign qual = cam_href && cam_pix_valid;

  assign rd_en = !f_empty && y_ready;
  assign room  = !f_full || rd_en;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    wr_pix    = cam_data;
    ovf_set   = 1'b0;
    skip_set  = 1'b0;
    case (state)
      WAIT_SOF: begin
        if (fall) begin
          state_nxt = CAPTURE;
          cnt_nxt   = '0;
        end
      end
      CAPTURE: begin
        if (qual && cnt != N_C) begin
          if (room) begin
            wr_en   = 1'b1;
            cnt_nxt = cnt + CW'(1);
          end else begin
            ovf_set   = 1'b1;
            state_nxt = DROP;
          end
        end
        if (rise) state_nxt = (cnt_nxt == N_C) ? WAIT_SOF : PAD;
      end
      DROP: begin
        if (rise) state_nxt = PAD;
      end
      PAD: begin
        wr_pix   = W'(PAD_VALUE);
        skip_set = fall;
        if (room) begin
          wr_en   = 1'b1;
          cnt_nxt = cnt + CW'(1);
          if (cnt_nxt == N_C) state_nxt = WAIT_SOF;
        end
      end
      default: state_nxt = WAIT_SOF;
    endcase
  end

  assign wr_dat = {cnt == '0, cnt == LAST_C, wr_pix};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_SOF;
      cnt           <= '0;
      vsync_q       <= 1'b1;
      vsync_primed  <= 1'b0;
      overflow      <= 1'b0;
      frame_skipped <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      vsync_q       <= cam_vsync;
      vsync_primed  <= 1'b1;
      overflow      <= overflow | ovf_set;
      frame_skipped <= skip_set;
    end
  end

  cam_fifo #(.W(W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_dat),
    .rd_en   (rd_en),
    .rd_data (rd_dat),
    .full    (f_full),
    .empty   (f_empty)
  );

  // Storage is not reset, so the data path is gated to read zero while empty
  assign y_valid   = !f_empty;
  assign y_data    = y_valid ? rd_dat[W-1:0] : '0;
  assign y_eof     = y_valid && rd_dat[W];
  assign y_sof     = y_valid && rd_dat[W+1];
  assign pix_count = cnt;
endmodule

// File: tb/tb_cam_stream_source.sv
// Directed bench for cam_stream_source at 4x2 pixels with a 4-entry FIFO.
module tb_cam_stream_source;
  localparam int W  = 8;
  localparam int IW = 4;
  localparam int IH = 2;
  localparam int N  = IW * IH;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cam_vsync = 1'b1;
  logic          cam_href = 1'b0;
  logic          cam_pix_valid = 1'b0;
  logic [W-1:0]  cam_data = '0;
  logic          y_valid;
  logic          y_ready = 1'b1;
  logic [W-1:0]  y_data;
  logic          y_sof, y_eof;
  logic          overflow, frame_skipped;
  logic [CW-1:0] pix_count;

  always #5 clk = ~clk;

  cam_stream_source #(
    .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(W), .FIFO_DEPTH(4), .PAD_VALUE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_pix_valid(cam_pix_valid),
    .cam_data(cam_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .y_sof(y_sof), .y_eof(y_eof),
    .overflow(overflow), .frame_skipped(frame_skipped), .pix_count(pix_count)
  );

  int checks = 0;
  int failures = 0;
  int skips = 0;
  int got_q[$];
  int exp_q[$];

  // Transfers are sampled mid-cycle; entries are encoded {sof, eof, data}
  always @(negedge clk) begin
    if (rst_n) begin
      if (y_valid && y_ready) got_q.push_back(int'({y_sof, y_eof, y_data}));
      if (frame_skipped) skips++;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic vs, input logic hr, input logic pv, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    cam_vsync     = vs;
    cam_href      = hr;
    cam_pix_valid = pv;
    cam_data      = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(cam_vsync, 1'b0, 1'b0, '0);
  endtask

  task automatic frame(input int base, input int npix);
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < npix; i++) cyc(1'b0, 1'b1, 1'b1, W'(base + i));
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    idle(2);
  endtask

  task automatic push_exp(input int d, input bit sof, input bit eof);
    exp_q.push_back(int'({sof, eof, 8'(d)}));
  endtask

  task automatic drain_check(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < 300 && got_q.size() < n; i++) @(posedge clk);
    idle(4);
    check_eq({tag, "_n"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      check_eq($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check_eq("rst_valid", int'(y_valid), 0);
    check_eq("rst_data", int'(y_data), 0);
    check_eq("rst_ovf", int'(overflow), 0);
    check_eq("rst_skip", int'(frame_skipped), 0);
    check_eq("rst_cnt", int'(pix_count), 0);
    rst_n = 1'b1;
    idle(3);

    // Clean frame
    frame(1, 8);
    check_eq("clean_cnt", int'(pix_count), 8);
    for (int i = 0; i < 8; i++) push_exp(1 + i, i == 0, i == 7);
    drain_check("clean");
    check_eq("clean_ovf", int'(overflow), 0);

    // Short frame padded with zeros
    frame(10, 5);
    for (int i = 0; i < 8; i++) push_exp(i < 5 ? 10 + i : 0, i == 0, i == 7);
    drain_check("short");
    check_eq("short_skip", skips, 0);

    // Long frame truncated, next frame aligned
    frame(20, 11);
    frame(40, 8);
    for (int i = 0; i < 8; i++) push_exp(20 + i, i == 0, i == 7);
    for (int i = 0; i < 8; i++) push_exp(40 + i, i == 0, i == 7);
    drain_check("long");

    // Overflow under backpressure
    y_ready = 1'b0;
    frame(50, 8);
    check_eq("ovf_set", int'(overflow), 1);
    check_eq("ovf_valid", int'(y_valid), 1);
    check_eq("ovf_data", int'(y_data), 50);
    check_eq("ovf_sof", int'(y_sof), 1);
    check_eq("ovf_cnt", int'(pix_count), 4);
    idle(3);
    check_eq("ovf_hold", int'(y_data), 50);
    y_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(i < 4 ? 50 + i : 0, i == 0, i == 7);
    drain_check("ovf");
    check_eq("ovf_sticky", int'(overflow), 1);

    // Next frame arrives while padding is stalled
    y_ready = 1'b0;
    frame(60, 3);
    frame(70, 8);
    check_eq("skip_pulse", skips, 1);
    y_ready = 1'b1;
    idle(12);
    frame(80, 8);
    for (int i = 0; i < 8; i++) push_exp(i < 3 ? 60 + i : 0, i == 0, i == 7);
    for (int i = 0; i < 8; i++) push_exp(80 + i, i == 0, i == 7);
    drain_check("skip");
    check_eq("skip_once", skips, 1);

    // Reset mid-capture
    y_ready = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, W'(90 + i));
    cyc(1'b0, 1'b0, 1'b0, '0);
    check_eq("mid_valid", int'(y_valid), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_valid", int'(y_valid), 0);
    check_eq("mrst_cnt", int'(pix_count), 0);
    idle(2);
    rst_n = 1'b1;
    y_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, W'(93 + i));
    idle(3);
    check_eq("post_valid", int'(y_valid), 0);
    check_eq("post_cnt", int'(pix_count), 0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    idle(2);
    frame(100, 8);
    for (int i = 0; i < 8; i++) push_exp(100 + i, i == 0, i == 7);
    drain_check("rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
